// File: rtl/fp_addsub_mc_pkg.sv
// Shared types and constants for the multi-cycle FP adder/subtractor.
// State and operand-class encodings, flag bit positions and default geometry.
package fp_addsub_mc_pkg;

  localparam int unsigned DefExpW   = 8;
  localparam int unsigned DefManW   = 23;
  localparam int unsigned W         = 1 + DefExpW + DefManW;
  localparam int unsigned GuardBits = 3;
  localparam int unsigned NumFlags  = 4;

  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound
  } state_e;

  typedef enum logic [1:0] {
    ClsZero,
    ClsFin,
    ClsInf,
    ClsNan
  } op_class_e;

  function automatic logic [NumFlags-1:0] flag_vec(input logic inv, input logic ovf,
                                                   input logic unf, input logic inx);
    logic [NumFlags-1:0] f;
    f                = '0;
    f[FlagInvalid]   = inv;
    f[FlagOverflow]  = ovf;
    f[FlagUnderflow] = unf;
    f[FlagInexact]   = inx;
    return f;
  endfunction

endpackage

// File: rtl/fp_addsub_mc_if.sv
// Request/response bundle between the control FSM and the FP adder/subtractor.
interface fp_addsub_mc_if
  import fp_addsub_mc_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned WordW = 1 + EXP_W + MAN_W;

  logic                start;
  logic                op;
  logic [WordW-1:0]    a;
  logic [WordW-1:0]    b;
  logic                busy;
  logic                done;
  logic [WordW-1:0]    result;
  logic [NumFlags-1:0] flags;

  modport master (output start, op, a, b, input busy, done, result, flags);
  modport slave  (input start, op, a, b, output busy, done, result, flags);

endinterface

// File: rtl/fp_addsub_mc_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns Width.
module fp_addsub_mc_lzc #(
  parameter int unsigned Width = 28
) (
  input  logic [Width-1:0]       data_i,
  output logic [$clog2(Width):0] cnt_o
);
  localparam int unsigned CntW = $clog2(Width) + 1;

  // Highest set bit wins because it is visited last.
  always_comb begin
    cnt_o = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (data_i[i]) cnt_o = CntW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_mc.sv
// Multi-cycle IEEE-754 adder/subtractor: IDLE -> ALIGN -> ADD -> NORM -> ROUND.
// Round-to-nearest-even, denormals flushed to zero, specials resolved at capture.
module fp_addsub_mc
  import fp_addsub_mc_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic           clk,
  input logic           reset_n,
  fp_addsub_mc_if.slave bus
);
  localparam int unsigned WordW = 1 + EXP_W + MAN_W;
  localparam int unsigned MW    = MAN_W + 1 + GuardBits;
  localparam int unsigned SW    = MW + 1;
  localparam int unsigned XW    = EXP_W + 2;
  localparam int unsigned CW    = $clog2(SW) + 1;
  localparam logic [EXP_W-1:0] ExpOnes = '1;
  localparam logic [WordW-1:0] QNaN = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic op_class_e classify(input logic [WordW-1:0] x);
    if (x[WordW-2:MAN_W] == ExpOnes) return (x[MAN_W-1:0] == '0) ? ClsInf : ClsNan;
    if (x[WordW-2:MAN_W] == '0) return ClsZero;
    return ClsFin;
  endfunction

  state_e              state_q;
  logic                busy_q, done_q;
  logic [WordW-1:0]    result_q, a_q, b_q, spec_res_q;
  logic [NumFlags-1:0] flags_q, spec_flg_q;
  logic                spec_q, sign_q, sub_q, zsign_q, zero_q, uf_q;
  logic signed [XW-1:0] exp_q;
  logic [MW-1:0]       mb_q, ms_q, man_q;
  logic [SW-1:0]       sum_q;

  // Capture: op flip, classification, denormal flush, special resolution
  logic [WordW-1:0]    b_in, a_cap, b_cap, spec_res_d;
  op_class_e           cls_a, cls_b;
  logic                spec_d;
  logic [NumFlags-1:0] spec_flg_d;

  assign b_in  = {bus.b[WordW-1] ^ bus.op, bus.b[WordW-2:0]};
  assign cls_a = classify(bus.a);
  assign cls_b = classify(b_in);
  assign a_cap = (cls_a == ClsZero) ? {bus.a[WordW-1], {(WordW-1){1'b0}}} : bus.a;
  assign b_cap = (cls_b == ClsZero) ? {b_in[WordW-1], {(WordW-1){1'b0}}} : b_in;

  always_comb begin
    spec_d     = 1'b0;
    spec_res_d = '0;
    spec_flg_d = '0;
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      spec_d     = 1'b1;
      spec_res_d = QNaN;
    end else if (cls_a == ClsInf && cls_b == ClsInf) begin
      spec_d = 1'b1;
      if (bus.a[WordW-1] != b_in[WordW-1]) begin
        spec_res_d = QNaN;
        spec_flg_d = flag_vec(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        spec_res_d = bus.a;
      end
    end else if (cls_a == ClsInf) begin
      spec_d     = 1'b1;
      spec_res_d = bus.a;
    end else if (cls_b == ClsInf) begin
      spec_d     = 1'b1;
      spec_res_d = b_in;
    end
  end

  // Align: order by magnitude, shift the smaller operand with a sticky collector
  logic [WordW-1:0] big, sml;
  logic [EXP_W-1:0] eb, es, d;
  logic [MW-1:0]    ext_s, shifted, lost_mask, mb_d, ms_d;
  logic             sticky;

  always_comb begin
    big       = (a_q[WordW-2:0] >= b_q[WordW-2:0]) ? a_q : b_q;
    sml       = (a_q[WordW-2:0] >= b_q[WordW-2:0]) ? b_q : a_q;
    eb        = big[WordW-2:MAN_W];
    es        = sml[WordW-2:MAN_W];
    d         = eb - es;
    mb_d      = {eb != '0, big[MAN_W-1:0], {GuardBits{1'b0}}};
    ext_s     = {es != '0, sml[MAN_W-1:0], {GuardBits{1'b0}}};
    lost_mask = ~({MW{1'b1}} << d);
    if (32'(d) >= MW) begin
      shifted = '0;
      sticky  = |ext_s;
    end else begin
      shifted = ext_s >> d;
      sticky  = |(ext_s & lost_mask);
    end
    ms_d = {shifted[MW-1:1], shifted[0] | sticky};
  end

  // Add: big >= small in magnitude, so the difference never goes negative
  logic [SW-1:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});

  // Normalise
  logic [CW-1:0]        lz;
  logic [MW-1:0]        man_n;
  logic signed [XW-1:0] exp_n;
  logic                 zero_n, uf_n;
  int                   exp_i;

  fp_addsub_mc_lzc #(.Width(SW)) u_lzc (
    .data_i({sum_q[SW-2:0], 1'b0}),
    .cnt_o (lz)
  );

  always_comb begin
    man_n  = '0;
    exp_n  = exp_q;
    zero_n = 1'b0;
    uf_n   = 1'b0;
    exp_i  = int'(exp_q);
    if (sum_q == '0) begin
      zero_n = 1'b1;
    end else if (sum_q[SW-1]) begin
      man_n = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      exp_i = int'(exp_q) + 1;
      exp_n = XW'(exp_i);
    end else begin
      man_n = sum_q[MW-1:0] << lz;
      exp_i = int'(exp_q) - int'(lz);
      exp_n = XW'(exp_i);
      uf_n  = (exp_i <= 0);
    end
  end

  // Round to nearest even and pack
  logic                inc, inx;
  logic [MAN_W+1:0]    mant_r;
  logic [MAN_W-1:0]    frac_r;
  int                  exp_r;
  logic [WordW-1:0]    res_r;
  logic [NumFlags-1:0] flg_r;

  always_comb begin
    inc    = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    inx    = |man_q[2:0];
    mant_r = {1'b0, man_q[MW-1:GuardBits]} + (MAN_W+2)'(inc);
    exp_r  = int'(exp_q) + (mant_r[MAN_W+1] ? 1 : 0);
    frac_r = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    if (spec_q) begin
      res_r = spec_res_q;
      flg_r = spec_flg_q;
    end else if (zero_q) begin
      res_r = {zsign_q, {(WordW-1){1'b0}}};
      flg_r = '0;
    end else if (uf_q) begin
      res_r = {sign_q, {(WordW-1){1'b0}}};
      flg_r = flag_vec(1'b0, 1'b0, 1'b1, 1'b1);
    end else if (exp_r >= int'(ExpOnes)) begin
      res_r = {sign_q, ExpOnes, {MAN_W{1'b0}}};
      flg_r = flag_vec(1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      res_r = {sign_q, exp_r[EXP_W-1:0], frac_r};
      flg_r = flag_vec(1'b0, 1'b0, 1'b0, inx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zsign_q    <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      ms_q       <= '0;
      sum_q      <= '0;
      man_q      <= '0;
      zero_q     <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q        <= a_cap;
            b_q        <= b_cap;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            busy_q     <= 1'b1;
            state_q    <= StAlign;
          end
        end
        StAlign: begin
          mb_q    <= mb_d;
          ms_q    <= ms_d;
          exp_q   <= $signed({2'b00, eb});
          sign_q  <= big[WordW-1];
          sub_q   <= big[WordW-1] ^ sml[WordW-1];
          zsign_q <= a_q[WordW-1] & b_q[WordW-1];
          state_q <= StAdd;
        end
        StAdd: begin
          sum_q   <= sum_d;
          state_q <= StNorm;
        end
        StNorm: begin
          man_q   <= man_n;
          exp_q   <= exp_n;
          zero_q  <= zero_n;
          uf_q    <= uf_n;
          state_q <= StRound;
        end
        StRound: begin
          result_q <= res_r;
          flags_q  <= flg_r;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fp_addsub_mc.sv
// Self-checking bench for fp_addsub_mc: directed vectors, handshake/reset sequences,
// and random operands against an exact-arithmetic single-precision model.
module tb_fp_addsub_mc;
  import fp_addsub_mc_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_addsub_mc_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_mc #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact value: operand = 1.frac * 2^(e-1) in units of 2^-149, summed as wide integers
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                    output logic [31:0] r, output logic [3:0] f);
    logic         sa, sb, sr, nan_a, nan_b, inf_a, inf_b, inx;
    int           ea, eb, p, e, sh;
    logic [299:0] x, y, mag, keep, low, half, one;
    sa    = a[31];
    sb    = b[31] ^ op;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    f     = 4'b0000;
    if (nan_a || nan_b) begin
      r = 32'h7FC0_0000;
      return;
    end
    if (inf_a && inf_b) begin
      if (sa != sb) begin
        r = 32'h7FC0_0000;
        f = 4'b1000;
      end else begin
        r = {sa, 8'hFF, 23'd0};
      end
      return;
    end
    if (inf_a) begin
      r = {sa, 8'hFF, 23'd0};
      return;
    end
    if (inf_b) begin
      r = {sb, 8'hFF, 23'd0};
      return;
    end
    x = (ea == 0) ? 300'd0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    y = (eb == 0) ? 300'd0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb) begin
      mag = x + y;
      sr  = sa;
    end else if (x >= y) begin
      mag = x - y;
      sr  = sa;
    end else begin
      mag = y - x;
      sr  = sb;
    end
    if (mag == 0) begin
      r = {sa & sb, 31'd0};
      return;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) begin
      r = {sr, 31'd0};
      f = 4'b0011;
      return;
    end
    sh   = p - 23;
    one  = 300'd1;
    keep = mag >> sh;
    low  = mag & ((one << sh) - one);
    inx  = (low != 0);
    if (sh > 0) begin
      half = one << (sh - 1);
      if (low > half || (low == half && keep[0])) keep = keep + one;
    end
    if (keep[24]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      r = {sr, 8'hFF, 23'd0};
      f = 4'b0101;
    end else begin
      r = {sr, 8'(e), keep[22:0]};
      f = {3'b000, inx};
    end
  endfunction

  // One request; lat is the number of falling edges from the accepting edge to done (0 = none)
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int guard;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb;
    bus.op    = top;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    r   = '0;
    f   = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        r   = bus.result;
        f   = bus.flags;
        break;
      end
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] r, ra, rb, er;
  logic [3:0]  f, ef;
  logic        rop;
  int          lat, mode, ndone;
  logic [15:0] done_mask;
  logic [31:0] hs_res[2];

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset flags", 64'(bus.flags), 64'd0);
    reset_n = 1'b1;

    vecs.push_back('{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000});
    vecs.push_back('{32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000, 4'b0000});
    vecs.push_back('{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001});
    vecs.push_back('{32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 4'b0001});
    vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000});
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000});
    vecs.push_back('{32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'b0000});
    vecs.push_back('{32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 4'b0000});
    vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0000});
    vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 4'b0000});
    vecs.push_back('{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'b0011});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
      check($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("vec%0d flags", i), 64'(f), 64'(vecs[i].flg));
    end

    // Start held for 12 cycles; operand a changes while busy and must not be re-captured
    while (bus.busy) @(negedge clk);
    @(negedge clk);
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h4000_0000;
    bus.op    = 1'b0;
    bus.start = 1'b1;
    done_mask = '0;
    ndone     = 0;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.a = 32'h4040_0000;
      if (k >= 1 && k <= 4) check($sformatf("hs busy c%0d", k), 64'(bus.busy), 64'd1);
      if (bus.done) begin
        done_mask[k] = 1'b1;
        if (ndone < 2) hs_res[ndone] = bus.result;
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("hs done cycles", 64'(done_mask), 64'h0420);
    check("hs result 1", 64'(hs_res[0]), 64'h4040_0000);
    check("hs result 2", 64'(hs_res[1]), 64'h40A0_0000);
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    check("hs drain idle", 64'(bus.busy), 64'd0);

    // Abort during NORM
    @(negedge clk);
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort result", 64'(bus.result), 64'd0);
    check("abort flags", 64'(bus.flags), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone   = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, r, f, lat);
    check("post-reset latency", 64'(lat), 64'd5);
    check("post-reset result", 64'(r), 64'h4040_0000);
    check("post-reset flags", 64'(f), 64'd0);

    // Random operands: plain, near exponents, cancellation, far alignment
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      ra   = $urandom;
      rb   = $urandom;
      rop  = 1'($urandom_range(0, 1));
      if (mode == 1) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 3));
      if (mode == 2) begin
        rb      = ra;
        rb[3:0] = 4'($urandom);
        rb[31]  = 1'($urandom_range(0, 1));
      end
      if (mode == 3) rb[30:23] = ra[30:23] - 8'($urandom_range(20, 30));
      ref_model(ra, rb, rop, er, ef);
      run_op(ra, rb, rop, r, f, lat);
      check($sformatf("rand%0d %h%s%h result", i, ra, rop ? "-" : "+", rb), 64'(r), 64'(er));
      check($sformatf("rand%0d %h%s%h flags", i, ra, rop ? "-" : "+", rb), 64'(f), 64'(ef));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_mc.md
# fp_addsub_mc

Multi-cycle, parametrised IEEE-754 binary floating-point adder/subtractor for the datapath FP unit, started and completed by the multi-cycle control FSM. Unlike the combinational single-precision adder it replaces, it supports:
- configurable exponent and mantissa widths;
- an explicit subtract operation;
- round-to-nearest-even with guard/round/sticky bits;
- full renormalisation after cancellation;
- special operands and exception flags.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = a+b, 1 = a-b (sign of b inverted at capture)
- a, b  in  W  operands, captured on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse: result and flags valid
- result  out  W  packed result, held until the next done
- flags  out  4  {invalid, overflow, underflow, inexact}, held with result

## Operation
- FSM states, in this fixed order: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. No other transitions exist.
- IDLE, start=1:
  - Latch a and b, applying the op sign flip to b.
  - Classify each operand as zero, finite, inf or NaN.
  - Go to ALIGN.
- start while busy is ignored; there is no queueing.
- Denormal inputs (exp=0, frac≠0) are flushed to signed zero. This never raises inexact.
- ALIGN:
  - Swap operands so that the larger-magnitude operand (exponent, then mantissa) is "big".
  - Extend both mantissas to hidden bit + MAN_W + 3 (G, R, S).
  - Shift "small" right by d = exp_big − exp_small. Every bit shifted past the R position is ORed into S.
  - If d > MAN_W+3, small becomes 0 with S = (small≠0).
- ADD:
  - Same effective sign: add into MAN_W+5 bits.
  - Otherwise: subtract small from big; the result is never negative.
  - Result sign is the sign of big.
- NORM:
  - Carry-out: shift right 1 (keep S sticky) and add 1 to the exponent.
  - Otherwise: left-shift by the leading-zero count from lzc, subtracting it from the exponent.
  - If the exponent would drop to ≤0, the result is signed zero with underflow=1 and inexact=1.
  - A zero sum gives +0. The exception is (−0)+(−0), which gives −0.
- ROUND:
  - Round to nearest even: increment when G & (R | S | lsb).
  - If the increment carries out, renormalise and add 1 to the exponent.
  - inexact = G | R | S.
  - If the exponent reaches all-ones: result ±inf, overflow=1, inexact=1.
- Specials are resolved at capture and carried through the same states:
  - Any NaN operand → canonical qNaN {0, all-ones, 1, zeros}.
  - inf − inf (effective) → qNaN with invalid=1.
  - inf ± finite → that inf, with no flags.
- On ROUND exit, register result and flags and pulse done.

## Timing
- Fixed latency. start is accepted at edge E0; states ALIGN, ADD, NORM and ROUND occupy edges E1..E3 and result is loaded at E4. done is high in the cycle following E4, and the FSM is in IDLE during that cycle.
- Back-to-back: start may be asserted in the done cycle. It is accepted, giving one result every 5 cycles.
- Reset values: state=IDLE, busy=0, done=0, result=0, flags=0, all internal registers 0.
- reset_n low mid-operation aborts immediately. done is not produced for the aborted request. The first start after release behaves exactly as from power-up.

## Structure
- A shared package holds:
  - the state encoding;
  - operand class encoding (ZERO, FIN, INF, NAN);
  - flag bit indices;
  - the localparams W and guard-bit count (3).
- Sub-module lzc, a parametrised leading-zero counter, is instantiated once in NORM. Its output width is $clog2(MAN_W+5)+1, and all-zero input returns the full width.
- Arithmetic is unsigned on mantissas. The exponent is held in EXP_W+2 signed bits so that underflow and overflow are detected before packing.

## Test plan
- 0x3F800000 + 0x40000000, op=0 → result 0x40400000, flags 0, done exactly 5 cycles after the start edge.
- 0x3F800000 − 0x3F7FFFFF (op=1) → 0x33800000, flags 0. This exercises a 24-bit cancellation renormalisation.
- Rounding:
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie, round to even), inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- Special and overflow cases:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x3F800000 − 0x3F800000 → 0x00000000.
- Handshake: start held high for 12 cycles → exactly 2 accepted requests, with done on cycles 5 and 10; start during busy is ignored.
- Reset: reset_n pulsed low during NORM → busy, done, result and flags go to 0 asynchronously. The next request (1.0+2.0) returns 0x40400000.
